// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Program counter and fetch stage. Drives the instruction ROM's combinational
//   read address and registers the returned word. The word is presented to the
//   decoder over a valid/ready handshake. The block handles sequential PC
//   increment, branch/jump redirect with flush, and downstream back-pressure.
//
// Optional feature macro: FETCH_HALT_EN
//   When defined, a fetched word equal to HALT_WORD stops fetching. The word is
//   still presented to the decoder. Fetching resumes on reset or on redirect.
//   When undefined, HALT_WORD is an ordinary instruction and halted is tied 0.
//
// Ports
//   clk          in   1        rising-edge clock
//   reset        in   1        synchronous, active-high reset
//   rom_addr     out  ADDR_W   ROM read address (combinational copy of pc)
//   rom_data     in   INSTR_W  ROM read data for rom_addr (zero latency)
//   redirect     in   1        branch/jump taken this cycle
//   redirect_pc  in   ADDR_W   target pc when redirect=1
//   instr_valid  out  1        instr/instr_pc hold a fetched instruction
//   instr_ready  in   1        decoder accepts instr this cycle
//   instr        out  INSTR_W  registered instruction word
//   instr_pc     out  ADDR_W   address instr was fetched from
//   halted       out  1        fetch stopped by HALT (FETCH_HALT_EN only)
//
// FSM (FETCH_HALT_EN builds only)
//   state     | meaning
//   ST_RUN    | fetching normally
//   ST_HALTED | HALT captured; no further fetches until reset or redirect

`ifndef ADDR_BITS
`define ADDR_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 8
`endif

module instruction_fetch #(
    parameter int                 ADDR_W    = `ADDR_BITS,
    parameter int                 INSTR_W   = 2 * `DATA_BITS,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] HALT_WORD = '1
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               halted
);

`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               valid_q, valid_d;
    logic               halted_int;
    logic               halt_hit;
    logic               advance;

`ifdef FETCH_HALT_EN
    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } fetch_state_t;

    fetch_state_t state_q, state_d;

    assign halted_int = (state_q == ST_HALTED);
`else
    assign halted_int = 1'b0;
`endif

    // Constant-false in the default build, so the hold-pc path folds away.
    assign halt_hit = HALT_EN && (rom_data == HALT_WORD);

    always_comb begin
        advance    = !halted_int && (!valid_q || instr_ready);
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
`ifdef FETCH_HALT_EN
        state_d    = state_q;
`endif
        if (redirect) begin
            // Flush the wrong-path word even under back-pressure; nothing is
            // captured this cycle, the target is fetched on the next edge.
            pc_d    = redirect_pc;
            valid_d = 1'b0;
`ifdef FETCH_HALT_EN
            state_d = ST_RUN;
`endif
        end else if (advance) begin
            instr_d    = rom_data;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            if (halt_hit) begin
                pc_d = pc_q;
`ifdef FETCH_HALT_EN
                state_d = ST_HALTED;
`endif
            end else begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end else if (halted_int && instr_ready) begin
            // HALT word (or nothing) transfers; no new word follows it.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
`ifdef FETCH_HALT_EN
            state_q    <= ST_RUN;
`endif
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
`ifdef FETCH_HALT_EN
            state_q    <= state_d;
`endif
        end
    end

    assign rom_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign halted      = halted_int;

endmodule
